// File: rtl/pc_branch_unit.sv
// Program counter, Z/V/N flag register with same-cycle bypass, condition evaluator
// and branch resolution with stall, halt, registered flush pulse and taken counter.
module pc_branch_unit #(
    parameter int                DATA_W   = 16,
    parameter int                IMM_W    = 9,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [2:0]        flag_we,
    input  logic [2:0]        flags_in,
    input  logic              branch_valid,
    input  logic              branch_reg,
    input  logic [2:0]        cond,
    input  logic [IMM_W-1:0]  imm,
    input  logic [DATA_W-1:0] reg_target,
    input  logic              halt_in,
    output logic [DATA_W-1:0] pc,
    output logic [2:0]        flags,
    output logic              flush,
    output logic              halted,
    output logic [CNT_W-1:0]  taken_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic        [DATA_W-1:0]  pc_next;
    logic        [2:0]         eff;
    logic                      cond_true;
    logic                      take;
    logic signed [DATA_W-1:0]  imm_ext;
    logic signed [DATA_W-1:0]  offset;
    logic        [DATA_W-1:0]  b_target;
    logic        [DATA_W-1:0]  br_target;
    logic        [DATA_W-1:0]  target;

    // eff is {N,V,Z}; GT means neither zero nor negative.
    function automatic logic cond_eval(input logic [2:0] cc, input logic [2:0] f);
        logic z;
        logic v;
        logic n;
        logic gt;
        logic res;
        z  = f[0];
        v  = f[1];
        n  = f[2];
        gt = !(z | n);
        case (cc)
            3'b000:  res = !z;
            3'b001:  res = z;
            3'b010:  res = gt;
            3'b011:  res = n;
            3'b100:  res = z | gt;
            3'b101:  res = !gt;
            3'b110:  res = v;
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    // A flag being written this cycle is seen by a branch in the same cycle.
    assign eff       = (flag_we & flags_in) | (~flag_we & flags);
    assign cond_true = cond_eval(cond, eff);

    assign imm_ext   = DATA_W'(signed'(imm));
    assign offset    = imm_ext <<< 1;
    assign b_target  = pc + DATA_W'(2) + $unsigned(offset);
    assign br_target = {reg_target[DATA_W-1:1], 1'b0};
    assign target    = branch_reg ? br_target : b_target;

    assign take   = branch_valid && cond_true && !stall && !halt_in && (state == RUN);
    assign halted = (state == HALTED);

    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            RUN: begin
                if (!stall) begin
                    if (halt_in) begin
                        state_next = HALTED;
                    end else if (take) begin
                        pc_next = target;
                    end else begin
                        pc_next = pc + DATA_W'(2);
                    end
                end
            end
            default: begin
                state_next = HALTED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            flags       <= 3'b000;
            flush       <= 1'b0;
            taken_count <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            flags       <= eff;
            flush       <= take;
            taken_count <= taken_count + CNT_W'(take);
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Randomized and directed bench for pc_branch_unit: a reference model pushes expected
// post-edge state into a queue, a monitor pops and compares after every rising edge.
module tb_pc_branch_unit;

    localparam logic [15:0] RPC = 16'h0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [2:0]  flag_we;
    logic [2:0]  flags_in;
    logic        branch_valid;
    logic        branch_reg;
    logic [2:0]  cond;
    logic [8:0]  imm;
    logic [15:0] reg_target;
    logic        halt_in;
    logic [15:0] pc;
    logic [2:0]  flags;
    logic        flush;
    logic        halted;
    logic [15:0] taken_count;

    pc_branch_unit #(.DATA_W(16), .IMM_W(9), .RESET_PC(RPC), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flag_we(flag_we), .flags_in(flags_in),
        .branch_valid(branch_valid), .branch_reg(branch_reg), .cond(cond), .imm(imm),
        .reg_target(reg_target), .halt_in(halt_in), .pc(pc), .flags(flags),
        .flush(flush), .halted(halted), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [2:0]  flags;
        logic        flush;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Model state
    int m_pc;
    int m_flags[3];
    bit m_halt;
    bit m_flush;
    int m_cnt;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit cond_model(input int c, input bit z, input bit v, input bit n);
        bit gt;
        gt = !(z || n);
        if (c == 0) return !z;
        if (c == 1) return z;
        if (c == 2) return gt;
        if (c == 3) return n;
        if (c == 4) return z || gt;
        if (c == 5) return !gt;
        if (c == 6) return v;
        return 1'b1;
    endfunction

    // Called at a falling edge after inputs are set; advances the model one clock.
    task automatic cycle();
        exp_t e;
        int eff[3];
        bit tk;
        int off;
        if (rst) begin
            m_pc = RPC; m_flags = '{0, 0, 0}; m_flush = 0; m_halt = 0; m_cnt = 0;
        end else begin
            for (int i = 0; i < 3; i++) eff[i] = flag_we[i] ? int'(flags_in[i]) : m_flags[i];
            tk = branch_valid && cond_model(int'(cond), eff[0] != 0, eff[1] != 0, eff[2] != 0)
                 && !stall && !halt_in && !m_halt;
            if (!m_halt && !stall) begin
                if (halt_in) begin
                    m_halt = 1;
                end else if (tk) begin
                    if (branch_reg) begin
                        m_pc = int'(reg_target) - (int'(reg_target) % 2);
                    end else begin
                        off = (int'(imm) >= 256) ? int'(imm) - 512 : int'(imm);
                        m_pc = (m_pc + 2 + 2 * off + 65536 * 4) % 65536;
                    end
                end else begin
                    m_pc = (m_pc + 2) % 65536;
                end
            end
            m_flags = eff;
            m_flush = tk;
            m_cnt = (m_cnt + (tk ? 1 : 0)) % 65536;
        end
        e.pc = 16'(m_pc);
        e.flags = {m_flags[2] != 0, m_flags[1] != 0, m_flags[0] != 0};
        e.flush = m_flush;
        e.halted = m_halt;
        e.cnt = 16'(m_cnt);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        stall = 0; flag_we = 0; flags_in = 0; branch_valid = 0; branch_reg = 0;
        cond = 0; imm = 0; reg_target = 0; halt_in = 0;
    endtask

    task automatic br(input bit is_reg, input logic [2:0] c, input logic [8:0] im,
                      input logic [15:0] rt);
        idle();
        branch_valid = 1; branch_reg = is_reg; cond = c; imm = im; reg_target = rt;
        cycle();
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("pc", int'(pc), int'(e.pc));
            check("flags", int'(flags), int'(e.flags));
            check("flush", int'(flush), int'(e.flush));
            check("halted", int'(halted), int'(e.halted));
            check("taken_count", int'(taken_count), int'(e.cnt));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        idle();
        m_pc = RPC; m_flags = '{0, 0, 0}; m_flush = 0; m_halt = 0; m_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        check("reset_pc", int'(pc), int'(RPC));
        check("reset_halted", int'(halted), 0);
        check("reset_cnt", int'(taken_count), 0);

        // Idle fetch from reset
        rst = 0;
        repeat (3) cycle();

        // BR to 0x0011 lands on 0x0010, then B imm=-3 lands on 0x000C
        br(1, 3'b111, 9'h000, 16'h0011);
        br(0, 3'b111, 9'h1FD, 16'h0000);
        idle(); cycle();

        // Flag bypass: Z registered 1, cleared in the same cycle as the branch
        idle(); flag_we = 3'b001; flags_in = 3'b001; cycle();
        idle(); flag_we = 3'b001; flags_in = 3'b000;
        branch_valid = 1; cond = 3'b001; imm = 9'd5; cycle();
        idle(); flag_we = 3'b001; flags_in = 3'b001; cycle();
        idle(); flag_we = 3'b001; flags_in = 3'b000;
        branch_valid = 1; cond = 3'b000; imm = 9'd5; cycle();

        // Register target and PC wrap-around
        br(1, 3'b111, 9'h000, 16'hABCD);
        br(1, 3'b111, 9'h000, 16'hFFFE);
        br(0, 3'b111, 9'h001, 16'h0000);
        br(0, 3'b111, 9'h004, 16'h0000);

        // Stall suppresses a taken branch
        idle(); stall = 1; branch_valid = 1; cond = 3'b111; imm = 9'd20; cycle();
        // Halt beats a simultaneous taken branch, then stays frozen
        idle(); halt_in = 1; branch_valid = 1; cond = 3'b111; imm = 9'd20; cycle();
        repeat (10) begin
            idle(); branch_valid = 1; cond = 3'b111; imm = 9'($urandom_range(0, 511));
            halt_in = 1'($urandom_range(0, 1)); flag_we = 3'($urandom_range(0, 7));
            flags_in = 3'($urandom_range(0, 7));
            cycle();
        end
        idle(); rst = 1; #1;
        check("async_rst_pc", int'(pc), int'(RPC));
        check("async_rst_halted", int'(halted), 0);
        @(negedge clk);
        m_pc = RPC; m_flags = '{0, 0, 0}; m_flush = 0; m_halt = 0; m_cnt = 0;
        rst = 0;
        cycle();

        // Condition sweep with bypassed flags, then with registered flags
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 8; c++) begin
                idle(); flag_we = 3'b111; flags_in = 3'(f);
                branch_valid = 1; cond = 3'(c); imm = 9'($urandom_range(0, 511));
                cycle();
            end
        end
        for (int f = 0; f < 8; f++) begin
            idle(); flag_we = 3'b111; flags_in = 3'(f); cycle();
            for (int c = 0; c < 8; c++) begin
                idle(); branch_valid = 1; branch_reg = 1'($urandom_range(0, 1));
                cond = 3'(c); imm = 9'($urandom_range(0, 511));
                reg_target = 16'($urandom_range(0, 65535));
                cycle();
            end
        end

        // Random traffic with occasional reset and halt
        for (int i = 0; i < 600; i++) begin
            idle();
            rst = ($urandom_range(0, 39) == 0);
            stall = ($urandom_range(0, 5) == 0);
            halt_in = ($urandom_range(0, 49) == 0);
            flag_we = 3'($urandom_range(0, 7));
            flags_in = 3'($urandom_range(0, 7));
            branch_valid = 1'($urandom_range(0, 1));
            branch_reg = 1'($urandom_range(0, 1));
            cond = 3'($urandom_range(0, 7));
            imm = 9'($urandom_range(0, 511));
            reg_target = 16'($urandom_range(0, 65535));
            cycle();
        end
        idle(); rst = 0;
        cycle();
        cycle();
        @(posedge clk);
        #2;
        check("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
